// File: rtl/rsa_pkg.sv
// Shared encodings for the register demux bank: write modes and bank state.
package rsa_pkg;

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'b00,
        MODE_AUTO  = 2'b01,
        MODE_BCAST = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/regdemux_bank_if.sv
// Word-in / bank-out bundle of regdemux_bank; master drives words and release, slave presents the bank.
interface regdemux_bank_if #(
    parameter int RSA_DW = 16,
    parameter int N_CH   = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic                   en;
    logic [1:0]             mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       sel;
    logic [RSA_DW-1:0]      din;
    logic                   consumed;
    logic [N_CH*RSA_DW-1:0] dout;
    logic [N_CH-1:0]        dout_vld;
    logic                   frame_done;
    logic                   sel_err;

    modport master (
        output en, mode, in_valid, sel, din, consumed,
        input  in_ready, dout, dout_vld, frame_done, sel_err
    );

    modport slave (
        input  en, mode, in_valid, sel, din, consumed,
        output in_ready, dout, dout_vld, frame_done, sel_err
    );
endinterface

// File: rtl/regdemux_lane.sv
// One output channel: data register plus loaded flag; write visible one cycle after wr.
// clr_all wipes data and flag, clr_vld drops only the flag so the consumer keeps the old data.
module regdemux_lane #(
    parameter int RSA_DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              clr_vld,
    input  logic              clr_all,
    input  logic [RSA_DW-1:0] din,
    output logic [RSA_DW-1:0] dat_q,
    output logic              vld_q
);
    logic [RSA_DW-1:0] dat_d;
    logic              vld_d;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (clr_all) begin
            dat_d = '0;
            vld_d = 1'b0;
        end else if (clr_vld) begin
            vld_d = 1'b0;
        end else if (wr) begin
            dat_d = din;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end
endmodule

// File: rtl/regdemux_bank.sv
// Collects words into N_CH channel registers and hands them over as one bank; 1-cycle write latency.
// in_ready drops while the bank is FULL until the consumer releases it with consumed.
module regdemux_bank #(
    parameter int RSA_DW = 16,
    parameter int N_CH   = 8
) (
    input  logic           clk,
    input  logic           sys_rst_n,
    regdemux_bank_if.slave bus
);
    import rsa_pkg::*;

    localparam int SEL_W = $clog2(N_CH);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              frame_done_q, frame_done_d;
    logic              sel_err_q, sel_err_d;
    logic [N_CH-1:0]   wr;
    logic [N_CH-1:0]   vld;
    logic              clr_vld, clr_all;
    logic              in_ready, xfer;
    mode_e             mode;
    logic [RSA_DW-1:0] lane_dat [N_CH];

    assign mode     = mode_e'(bus.mode);
    assign in_ready = bus.en && (state_q == ST_FILL);
    assign xfer     = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_FILL;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
            sel_err_q    <= sel_err_d;
        end
    end

    // The bank goes FULL on the edge whose own write completes the valid mask.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_FILL;
        end else if (state_q == ST_FULL) begin
            if (bus.consumed) state_d = ST_FILL;
        end else if (xfer && (&(vld | wr))) begin
            state_d = ST_FULL;
        end
    end

    always_comb begin
        clr_all      = !bus.en;
        clr_vld      = bus.en && (state_q == ST_FULL) && bus.consumed;
        wr           = '0;
        ptr_d        = ptr_q;
        sel_err_d    = 1'b0;
        if (clr_all || clr_vld) begin
            ptr_d = '0;
        end else if (xfer) begin
            unique case (mode)
                MODE_ADDR: begin
                    if (int'(bus.sel) < N_CH) begin
                        for (int c = 0; c < N_CH; c++) wr[c] = (int'(bus.sel) == c);
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                MODE_AUTO: begin
                    for (int c = 0; c < N_CH; c++) wr[c] = (int'(ptr_q) == c);
                    ptr_d = (int'(ptr_q) == N_CH - 1) ? '0 : ptr_q + SEL_W'(1);
                end
                MODE_BCAST: wr = '1;
                default: ;
            endcase
        end
        frame_done_d = xfer && (&(vld | wr));
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        regdemux_lane #(.RSA_DW(RSA_DW)) u_lane (
            .clk     (clk),
            .rst_n   (sys_rst_n),
            .wr      (wr[c]),
            .clr_vld (clr_vld),
            .clr_all (clr_all),
            .din     (bus.din),
            .dat_q   (lane_dat[c]),
            .vld_q   (vld[c])
        );
    end

    always_comb begin
        bus.dout = '0;
        for (int c = 0; c < N_CH; c++) bus.dout[c*RSA_DW +: RSA_DW] = lane_dat[c];
    end

    assign bus.in_ready   = in_ready;
    assign bus.dout_vld   = vld;
    assign bus.frame_done = frame_done_q;
    assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_regdemux_bank.sv
// Drives an 8-channel and a 6-channel bank with identical stimulus and scoreboards both against a behavioural model.
module tb_regdemux_bank;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;

    regdemux_bank_if #(.RSA_DW(16), .N_CH(8)) bus8 ();
    regdemux_bank_if #(.RSA_DW(16), .N_CH(6)) bus6 ();

    regdemux_bank #(.RSA_DW(16), .N_CH(8)) dut8 (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus8));
    regdemux_bank #(.RSA_DW(16), .N_CH(6)) dut6 (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus6));

    assign bus6.en       = bus8.en;
    assign bus6.mode     = bus8.mode;
    assign bus6.in_valid = bus8.in_valid;
    assign bus6.sel      = bus8.sel;
    assign bus6.din      = bus8.din;
    assign bus6.consumed = bus8.consumed;

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][15:0] dat;
        logic [7:0]       vld;
        logic             full;
        logic             fd;
        logic             se;
    } snap_t;

    snap_t q8[$];
    snap_t q6[$];

    logic [7:0][15:0] m_dat  [2];
    logic [7:0]       m_vld  [2];
    int               m_ptr  [2];
    logic             m_full [2];
    logic             m_fd   [2];
    logic             m_se   [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int nch(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic model_clear(input int k);
        m_dat[k]  = '0;
        m_vld[k]  = '0;
        m_ptr[k]  = 0;
        m_full[k] = 1'b0;
        m_fd[k]   = 1'b0;
        m_se[k]   = 1'b0;
    endtask

    task automatic model_write(input int k, input int ch);
        m_dat[k][ch] = bus8.din;
        m_vld[k][ch] = 1'b1;
    endtask

    // One clock edge of the bank as described behaviourally: clear, release, or accept a word.
    task automatic model_edge(input int k);
        int n;
        logic [7:0] all_ones;
        n = nch(k);
        all_ones = 8'hFF >> (8 - n);
        m_fd[k] = 1'b0;
        m_se[k] = 1'b0;
        if (!bus8.en) begin
            model_clear(k);
        end else if (m_full[k]) begin
            if (bus8.consumed) begin
                m_vld[k]  = '0;
                m_ptr[k]  = 0;
                m_full[k] = 1'b0;
            end
        end else if (bus8.in_valid) begin
            case (bus8.mode)
                2'b00: if (int'(bus8.sel) < n) model_write(k, int'(bus8.sel)); else m_se[k] = 1'b1;
                2'b01: begin
                    model_write(k, m_ptr[k]);
                    m_ptr[k] = (m_ptr[k] + 1) % n;
                end
                2'b10: for (int c = 0; c < n; c++) model_write(k, c);
                default: ;
            endcase
            if (m_vld[k] == all_ones) begin
                m_full[k] = 1'b1;
                m_fd[k]   = 1'b1;
            end
        end
    endtask

    function automatic snap_t snap(input int k);
        snap_t s;
        s.dat  = m_dat[k];
        s.vld  = m_vld[k];
        s.full = m_full[k];
        s.fd   = m_fd[k];
        s.se   = m_se[k];
        return s;
    endfunction

    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            model_clear(0);
            model_clear(1);
            q8.delete();
            q6.delete();
        end else begin
            model_edge(0);
            model_edge(1);
        end
        q8.push_back(snap(0));
        q6.push_back(snap(1));
    end

    task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic check_bank(input string tag, input snap_t s, input logic [127:0] dout,
                              input logic [7:0] vld, input logic fd, input logic se, input logic rdy);
        cmp({tag, " dout"}, dout, 128'(s.dat));
        cmp({tag, " dout_vld"}, 128'(vld), 128'(s.vld));
        cmp({tag, " frame_done"}, 128'(fd), 128'(s.fd));
        cmp({tag, " sel_err"}, 128'(se), 128'(s.se));
        cmp({tag, " in_ready"}, 128'(rdy), 128'(!s.full && bus8.en));
    endtask

    // Monitor: the newest expected snapshot is compared against what each bank presents.
    always @(negedge clk) begin
        snap_t s;
        if (q8.size() > 0) begin
            while (q8.size() > 1) void'(q8.pop_front());
            s = q8.pop_front();
            check_bank("b8", s, 128'(bus8.dout), bus8.dout_vld, bus8.frame_done, bus8.sel_err, bus8.in_ready);
        end
        if (q6.size() > 0) begin
            while (q6.size() > 1) void'(q6.pop_front());
            s = q6.pop_front();
            check_bank("b6", s, 128'(bus6.dout), 8'(bus6.dout_vld), bus6.frame_done, bus6.sel_err, bus6.in_ready);
        end
    end

    task automatic drive(input logic v, input logic [1:0] m, input logic [2:0] s,
                         input logic [15:0] d, input logic c = 1'b0, input logic e = 1'b1);
        @(posedge clk);
        #1;
        bus8.in_valid = v;
        bus8.mode     = m;
        bus8.sel      = s;
        bus8.din      = d;
        bus8.consumed = c;
        bus8.en       = e;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 2'b11, 3'd0, 16'h0);
    endtask

    initial begin
        bus8.en       = 1'b0;
        bus8.mode     = 2'b00;
        bus8.in_valid = 1'b0;
        bus8.sel      = '0;
        bus8.din      = '0;
        bus8.consumed = 1'b0;
        repeat (2) @(posedge clk);
        #1 sys_rst_n = 1'b1;
        idle(1);

        // Addressed fill c=7..0; b6 flags sel 7 and 6 as errors.
        for (int c = 7; c >= 0; c--) drive(1'b1, 2'b00, 3'(c), 16'h1000 + 16'(c));
        idle(2);
        drive(1'b0, 2'b11, 3'd0, 16'h0, 1'b1);
        idle(2);

        // Auto-increment with wrap, release, then one more word.
        for (int i = 0; i < 8; i++) drive(1'b1, 2'b01, 3'd0, 16'h00A0 + 16'(i));
        drive(1'b0, 2'b11, 3'd0, 16'h0, 1'b1);
        drive(1'b1, 2'b01, 3'd0, 16'h00B0);
        drive(1'b1, 2'b01, 3'd0, 16'h00B1);
        idle(1);

        // Clear, then broadcast into an empty bank.
        drive(1'b0, 2'b11, 3'd0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 3'd0, 16'hBEEF);
        idle(2);
        drive(1'b0, 2'b11, 3'd0, 16'h0, 1'b1);

        // Overwrite ch2, hold words, then complete the bank.
        drive(1'b1, 2'b00, 3'd2, 16'h0011);
        drive(1'b1, 2'b00, 3'd2, 16'h0022);
        drive(1'b1, 2'b11, 3'd5, 16'hDEAD);
        drive(1'b1, 2'b11, 3'd0, 16'hDEAD);
        for (int c = 0; c < 8; c++) if (c != 2) drive(1'b1, 2'b00, 3'(c), 16'h2000 + 16'(c));
        idle(2);
        drive(1'b0, 2'b11, 3'd0, 16'h0, 1'b1);

        // en low after three auto writes.
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b01, 3'd0, 16'h0300 + 16'(i));
        drive(1'b1, 2'b01, 3'd0, 16'h0399, 1'b0, 1'b0);
        idle(1);

        // Async reset pulse between edges.
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b01, 3'd0, 16'h0400 + 16'(i));
        @(posedge clk);
        #2 sys_rst_n = 1'b0;
        #1;
        cmp("async dout_vld", 128'(bus8.dout_vld), 128'h0);
        cmp("async dout", 128'(bus8.dout), 128'h0);
        #1 sys_rst_n = 1'b1;
        idle(1);

        // consumed together with en=0 on a full bank.
        drive(1'b1, 2'b10, 3'd0, 16'h5A5A);
        idle(1);
        drive(1'b0, 2'b11, 3'd0, 16'h0, 1'b1, 1'b0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  16'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) != 0));
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regdemux_bank.md
# regdemux_bank

Parametrised registered demultiplexer that collects a stream of RSA_DW-bit words into N_CH output registers and presents them as one bank to the systolic array. Successor to the fixed 8-way register demux: it adds a valid/ready handshake, per-channel valid flags, addressed, auto-increment and broadcast write modes, and a FILL/FULL bank state machine with a release handshake from the consumer.

## Interface
- RSA_DW, 16, data width of one word
- N_CH, 8, number of output channels (≥2; need not be a power of 2)
- SEL_W, $clog2(N_CH), channel index width (derived localparam, not overridable)

- clk  in  1  system clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- en  in  1  synchronous enable; low = synchronous clear of all state
- mode  in  2  00 addressed, 01 auto-increment, 10 broadcast, 11 hold (accept, no write)
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- sel  in  SEL_W  target channel in addressed mode
- din  in  RSA_DW  input word
- consumed  in  1  downstream has read the full bank; release it
- dout  out  N_CH*RSA_DW  channel c at bits [c*RSA_DW +: RSA_DW]
- dout_vld  out  N_CH  per-channel loaded flag
- frame_done  out  1  one-cycle pulse when the bank becomes full
- sel_err  out  1  one-cycle pulse on an addressed write with sel ≥ N_CH

## Operation
- Reset (async, sys_rst_n=0): dout=0, dout_vld=0, ptr=0, state=FILL, frame_done=0, sel_err=0.
- en=0 at a clock edge: same values as reset, applied synchronously. in_ready=0 while en=0.
- A transfer occurs when in_valid && in_ready at a rising edge.
- States:
  - FILL: in_ready = en.
  - FULL: in_ready = 0.
- Addressed write (mode 00):
  - sel < N_CH: dout[sel]←din, dout_vld[sel]←1. Overwriting an already-valid channel is legal.
  - sel ≥ N_CH: no write; sel_err pulses.
- Auto-increment write (mode 01): dout[ptr]←din, dout_vld[ptr]←1, then ptr←ptr+1, wrapping N_CH-1→0.
- Broadcast write (mode 10): every channel ←din, all dout_vld←1.
- Hold (mode 11): word is accepted and discarded; no state change.
- Transition FILL→FULL: at the edge where the update makes dout_vld all-ones. frame_done=1 for exactly the following cycle.
- Transition FULL→FILL: consumed=1 at an edge. dout_vld←0 and ptr←0; dout data is retained. consumed is ignored in FILL.
- Mode or sel changes mid-frame affect only later transfers. ptr is advanced only by mode-01 transfers.

## Timing
- in_ready is combinational from state and en, with no dependency on in_valid.
- Write latency is one cycle: a word accepted at edge k is visible on dout/dout_vld after edge k.
- frame_done and sel_err are registered and high in the cycle after the causing edge.
- Minimum bank turnaround is N_CH+1 cycles in mode 01 (N_CH writes plus one consumed cycle), and 2 cycles in broadcast.
- en=0 takes priority over consumed and transfers at the same edge. Async reset takes priority over everything.
- Reset deasserted mid-frame leaves the bank empty in FILL. A partial frame is never reported.

## Structure
- Shared package rsa_pkg:
  - mode encodings MODE_ADDR, MODE_AUTO, MODE_BCAST, MODE_HOLD
  - state enum {ST_FILL, ST_FULL}
- Sub-module regdemux_lane (one per channel, generate loop): holds the RSA_DW data register and valid flag, with inputs wr, clr_vld and clr_all.
- Top level holds the FSM, ptr counter, decode and pulse registers.

## Test plan
- Addressed fill, N_CH=8: write 0x1000+c to sel=c for c=7..0. frame_done pulses once after the 8th write, dout_vld=0xFF, in_ready=0; consumed=1 → dout_vld=0x00, data retained, in_ready=1.
- Auto-increment with wrap: write 0xA0..0xA7, consumed, then write 0xB0. 0xB0 lands in ch0 with ptr=1 and dout_vld=0x01.
- Broadcast 0xBEEF from an empty bank: all channels 0xBEEF, dout_vld=0xFF the next cycle, frame_done pulses.
- N_CH=6, addressed write with sel=7: no channel changes, sel_err pulses once, in_ready stays 1.
- Overwrite ch2 twice (0x11 then 0x22) before the bank is full: ch2=0x22 and frame_done does not fire early. Hold-mode words change nothing.
- Drop en low after 3 auto writes: all outputs 0 next cycle. Pulsing sys_rst_n low between edges clears immediately (async). Set consumed=1 together with en=0: stays in FILL, no stray frame_done.
